// File: rtl/roteador_arbitro_if.sv
// Handshake bundle between the round-robin arbiter and its consumer.
// The arbiter drives the grant side; the requester side drives req/ready.
interface roteador_arbitro_if #(
    parameter int SEL_BITS = 2
);
    logic [3:0]          req;
    logic                ready;
    logic [SEL_BITS-1:0] sel;
    logic [3:0]          gnt;
    logic                valid;
    logic                busy;

    modport master (
        input  req,
        input  ready,
        output sel,
        output gnt,
        output valid,
        output busy
    );

    modport slave (
        output req,
        output ready,
        input  sel,
        input  gnt,
        input  valid,
        input  busy
    );
endinterface

// File: rtl/roteador_arbitro.sv
// Round-robin arbiter feeding the 4:1 router SEL, with bounded burst per grant.
// All outputs registered; release re-arbitrates in the same edge (no bubble).
module roteador_arbitro #(
    parameter int SEL_BITS = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    roteador_arbitro_if.master   bus
);
    localparam int N = 2 ** SEL_BITS;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [SEL_BITS-1:0] r_ptr;
    logic [SEL_BITS-1:0] w_ptr_n;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_n;
    logic [SEL_BITS-1:0] r_sel;
    logic [SEL_BITS-1:0] w_sel_n;
    logic [N-1:0]        r_gnt;
    logic [N-1:0]        w_gnt_n;

    logic                w_busy;
    logic                w_xfer;
    logic [3:0]          w_cnt_inc;
    logic                w_release;
    logic [SEL_BITS-1:0] w_start;
    logic                w_found;
    logic [SEL_BITS-1:0] w_win;

    assign w_busy    = (r_state == GRANT);
    assign w_xfer    = w_busy && bus.ready;
    assign w_cnt_inc = r_cnt + 4'd1;
    assign w_release = w_busy &&
                       (!bus.req[r_sel] ||
                        (w_xfer && w_cnt_inc == 4'(MAX_HOLD)));
    assign w_start   = w_release ? r_sel + 1'b1 : r_ptr;

    // Cyclic first-set search; lowest offset from w_start wins.
    always_comb begin
        logic [SEL_BITS-1:0] v_idx;
        v_idx   = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            v_idx = w_start + SEL_BITS'(k);
            if (bus.req[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_cnt_n   = r_cnt;
        w_sel_n   = r_sel;
        w_gnt_n   = r_gnt;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_n = GRANT;
                    w_sel_n   = w_win;
                    w_gnt_n   = N'(1) << w_win;
                    w_cnt_n   = 4'd0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_ptr_n = r_sel + 1'b1;
                    w_cnt_n = 4'd0;
                    if (w_found) begin
                        w_sel_n = w_win;
                        w_gnt_n = N'(1) << w_win;
                    end else begin
                        w_state_n = IDLE;
                        w_gnt_n   = '0;
                    end
                end else if (w_xfer) begin
                    w_cnt_n = w_cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= 4'd0;
            r_sel   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_ptr   <= w_ptr_n;
            r_cnt   <= w_cnt_n;
            r_sel   <= w_sel_n;
            r_gnt   <= w_gnt_n;
        end
    end

    assign bus.sel   = r_sel;
    assign bus.gnt   = r_gnt;
    assign bus.valid = w_busy;
    assign bus.busy  = w_busy;
endmodule

// File: tb/tb_roteador_arbitro.sv
// Directed bench for roteador_arbitro: vector table plus multi-cycle corner cases.
// Outputs are sampled 1ns after the rising edge; invariants checked on falling edge.
module tb_roteador_arbitro;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    roteador_arbitro_if #(.SEL_BITS(2)) bus ();

    roteador_arbitro #(
        .SEL_BITS(2),
        .MAX_HOLD(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic       ready;
        logic [1:0] exp_sel;
        logic [3:0] exp_gnt;
        logic       exp_valid;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit r, input logic [3:0] rq, input logic rd,
                       input logic [1:0] s, input logic [3:0] g, input logic v);
        vec_t t;
        t.rst = r; t.req = rq; t.ready = rd;
        t.exp_sel = s; t.exp_gnt = g; t.exp_valid = v;
        vq.push_back(t);
    endtask

    task automatic check(input string name, input logic [1:0] s,
                         input logic [3:0] g, input logic v);
        checks++;
        if (bus.sel !== s || bus.gnt !== g || bus.valid !== v || bus.busy !== v) begin
            errors++;
            $display("FAIL %s: got sel=%0d gnt=%b valid=%b busy=%b, want sel=%0d gnt=%b valid=%b busy=%b",
                     name, bus.sel, bus.gnt, bus.valid, bus.busy, s, g, v, v);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (bus.gnt !== 4'b0000 || bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: got gnt=%b valid=%b busy=%b, want gnt=0000 valid=0 busy=0",
                     name, bus.gnt, bus.valid, bus.busy);
        end
    endtask

    task automatic step(input logic [3:0] rq, input logic rd);
        bus.req   = rq;
        bus.ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req   = 4'b0000;
        bus.ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (bus.valid !== bus.busy ||
                (bus.busy && bus.gnt !== (4'b0001 << bus.sel)) ||
                (!bus.busy && bus.gnt !== 4'b0000)) begin
                errors++;
                $display("FAIL invariant: sel=%0d gnt=%b valid=%b busy=%b",
                         bus.sel, bus.gnt, bus.valid, bus.busy);
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        bus.req   = 4'b0000;
        bus.ready = 1'b0;

        // single requester C: 1-cycle latency, re-grant with no gap
        add(1, 4'b0100, 1, 2'd2, 4'b0100, 1);
        for (int i = 0; i < 6; i++) add(0, 4'b0100, 1, 2'd2, 4'b0100, 1);
        // all requesting: A,B,C,D,A each for 4 transfers
        add(1, 4'b1111, 1, 2'd0, 4'b0001, 1);
        for (int i = 0; i < 3; i++) add(0, 4'b1111, 1, 2'd0, 4'b0001, 1);
        for (int i = 0; i < 4; i++) add(0, 4'b1111, 1, 2'd1, 4'b0010, 1);
        for (int i = 0; i < 4; i++) add(0, 4'b1111, 1, 2'd2, 4'b0100, 1);
        for (int i = 0; i < 4; i++) add(0, 4'b1111, 1, 2'd3, 4'b1000, 1);
        for (int i = 0; i < 2; i++) add(0, 4'b1111, 1, 2'd0, 4'b0001, 1);

        do_reset();
        check("reset_state", 2'd0, 4'b0000, 1'b0);

        foreach (vq[i]) begin
            if (vq[i].rst) do_reset();
            step(vq[i].req, vq[i].ready);
            check($sformatf("vec%0d", i), vq[i].exp_sel, vq[i].exp_gnt, vq[i].exp_valid);
        end

        // reset mid-burst: C granted with cnt=2
        do_reset();
        step(4'b0100, 1);
        step(4'b0100, 1);
        step(4'b0100, 1);
        check("c_before_reset", 2'd2, 4'b0100, 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset", 2'd0, 4'b0000, 0);
        bus.req = 4'b0001;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(4'b0001, 1);
        check("after_reset_a", 2'd0, 4'b0001, 1);

        // stall on B, then 4 transfers before rotating to A
        do_reset();
        step(4'b0010, 0);
        check("b_grant", 2'd1, 4'b0010, 1);
        for (int i = 0; i < 10; i++) step(4'b0011, 0);
        check("b_stall_hold", 2'd1, 4'b0010, 1);
        for (int i = 0; i < 3; i++) step(4'b0011, 1);
        check("b_after_3_xfer", 2'd1, 4'b0010, 1);
        step(4'b0011, 1);
        check("b_rotate_to_a", 2'd0, 4'b0001, 1);

        // early drop by D, pointer wraps to A
        do_reset();
        step(4'b1000, 1);
        check("d_grant", 2'd3, 4'b1000, 1);
        step(4'b1000, 1);
        step(4'b1000, 1);
        step(4'b0011, 1);
        check("d_drop_to_a", 2'd0, 4'b0001, 1);

        // drop with the 4th transfer: single release to IDLE, ptr=1
        do_reset();
        step(4'b0001, 1);
        step(4'b0001, 1);
        step(4'b0001, 1);
        step(4'b0001, 1);
        check("a_cnt3", 2'd0, 4'b0001, 1);
        step(4'b0000, 1);
        check_idle("drop_at_limit_idle");
        step(4'b0011, 1);
        check("ptr1_b_first", 2'd1, 4'b0010, 1);

        // drop with ready=0 still releases
        step(4'b0001, 0);
        check("drop_stalled", 2'd0, 4'b0001, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
